ifetch_unit: RTL

Instruction fetch stage sitting directly downstream of the PC register. It takes the current fetch address and runs a valid/ready request and response exchange with instruction memory, which may have variable latency. It holds the fetched word for decode until decode accepts it, then pulses a PC-advance enable back to the PC hold mux. It also handles redirect flushes, discards stale responses, and flags misaligned-address and bus-error faults.

---
 rtl/ifetch_pkg.sv | 9 +
 rtl/ifetch_ireg.sv | 44 ++++
 rtl/ifetch_unit.sv | 102 ++++++++++
 3 files changed

// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared state encoding and constants for the instruction fetch stage
package ifetch_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, FULL = 2'd3} state_e;
   localparam logic [31:0] INSTR_NOP = 32'h0000_0013;
   localparam logic [1:0] ALIGN_MASK = 2'b11;
   function automatic logic misaligned(input logic [31:0] addr);
      return (addr[1:0] & ALIGN_MASK) != 2'b00;
   endfunction
endpackage

// File: rtl/ifetch_ireg.sv
// ifetch_ireg: instruction/pc/fault holding register presented to decode
module ifetch_ireg
   import ifetch_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        load_i,
   input  logic        clear_i,
   input  logic [31:0] instr_i,
   input  logic [31:0] pc_i,
   input  logic        fault_i,
   output logic        valid_o,
   output logic [31:0] instr_o,
   output logic [31:0] pc_o,
   output logic        fault_o
);
   logic        valid_q;
   logic [31:0] instr_q;
   logic [31:0] pc_q;
   logic        fault_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q <= 1'b0;
         instr_q <= INSTR_NOP;
         pc_q    <= '0;
         fault_q <= 1'b0;
      end else if (load_i) begin
         valid_q <= 1'b1;
         instr_q <= fault_i ? INSTR_NOP : instr_i;
         pc_q    <= pc_i;
         fault_q <= fault_i;
      end else if (clear_i) begin
         valid_q <= 1'b0;
         instr_q <= INSTR_NOP;
         fault_q <= 1'b0;
      end
   end

   assign valid_o = valid_q;
   assign instr_o = instr_q;
   assign pc_o    = pc_q;
   assign fault_o = fault_q;
endmodule

// File: rtl/ifetch_unit.sv
// ifetch_unit: single-outstanding fetch FSM between the PC register, instruction memory and decode
module ifetch_unit
   import ifetch_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] pc,
   output logic        pc_advance,
   input  logic        flush,
   output logic        imem_req_valid,
   output logic [31:0] imem_req_addr,
   input  logic        imem_req_ready,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        imem_rsp_err,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   output logic        fetch_fault
);
   state_e      state_q, state_d;
   logic        discard_q, discard_d;
   logic [31:0] addr_q, addr_d;
   logic        req_valid_q;
   logic        load, clear, ld_fault;
   logic [31:0] ld_pc;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         discard_q   <= 1'b0;
         addr_q      <= '0;
         req_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         discard_q   <= discard_d;
         addr_q      <= addr_d;
         req_valid_q <= state_d == REQ;
      end
   end

   // a flush during REQ/WAIT cannot cancel the memory transaction, so its response is marked stale
   always_comb begin
      state_d   = state_q;
      discard_d = discard_q;
      addr_d    = addr_q;
      load      = 1'b0;
      clear     = 1'b0;
      ld_pc     = addr_q;
      ld_fault  = imem_rsp_err;
      case (state_q)
         IDLE: if (!flush) begin
            if (misaligned(pc)) begin
               state_d  = FULL;
               load     = 1'b1;
               ld_pc    = pc;
               ld_fault = 1'b1;
            end else begin
               state_d = REQ;
               addr_d  = pc;
            end
         end
         REQ: begin
            if (flush) discard_d = 1'b1;
            if (imem_req_ready) state_d = WAIT;
         end
         WAIT: if (imem_rsp_valid) begin
            if (discard_q || flush) begin
               discard_d = 1'b0;
               state_d   = IDLE;
            end else begin
               state_d = FULL;
               load    = 1'b1;
            end
         end else if (flush) discard_d = 1'b1;
         FULL: if (flush || instr_ready) begin
            state_d = IDLE;
            clear   = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   ifetch_ireg u_ireg (
      .clk     (clk),
      .reset   (reset),
      .load_i  (load),
      .clear_i (clear),
      .instr_i (imem_rsp_data),
      .pc_i    (ld_pc),
      .fault_i (ld_fault),
      .valid_o (instr_valid),
      .instr_o (instr),
      .pc_o    (instr_pc),
      .fault_o (fetch_fault)
   );

   assign pc_advance     = (state_q == FULL) && instr_ready && !flush;
   assign imem_req_valid = req_valid_q;
   assign imem_req_addr  = addr_q;
endmodule
